add_sub_seq: RTL and testbench
==============================

ADD_SUB_SEQ -- requirements
Module: add_sub_seq

Interface
REQ-001: Parameter NBYTES, default 4; maximum operand length in bytes.
REQ-002: Parameter BYTE_W, default 8; byte width; SHALL match the downstream add/sub datapath.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: start  input  1  request a new operation; sampled only in IDLE.
REQ-006: sub  input  1  0 = add, 1 = subtract (a - b).
REQ-007: len  input  2  operand length minus one (0 = 1 byte ... 3 = 4 bytes).
REQ-008: a_word  input  32  operand A, little-endian bytes.
REQ-009: b_word  input  32  operand B, little-endian bytes.
REQ-010: alu_a, alu_b  output  8 each  byte pair driven to the add/sub datapath.
REQ-011: alu_csel  output  1  1 = use stored carry as carry-in; 0 = use alu_sub_sel.
REQ-012: alu_sub_sel  output  1  subtract select to the datapath.
REQ-013: alu_cclear  output  1  carry-register enable to the datapath.
REQ-014: alu_eop  output  1  end-of-operation; enables datapath sign/zero flag capture.
REQ-015: alu_s  input  8  sum byte returned combinationally by the datapath.
REQ-016: result  output  32  assembled result, little-endian.
REQ-017: busy  output  1  high from start acceptance until done is asserted.
REQ-018: done  output  1  one-cycle pulse; result valid.

Function
REQ-019: FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when idx == len; DONE->IDLE unconditionally.
REQ-020: On start in IDLE, a_word, b_word, sub, len SHALL be captured; idx and result SHALL be cleared.
REQ-021: In RUN, alu_a/alu_b SHALL carry byte idx of the captured operands; idx SHALL increment by 1 each cycle.
REQ-022: alu_csel SHALL be 0 when idx == 0 (carry-in = sub) and 1 for idx > 0 (chained carry).
REQ-023: alu_sub_sel SHALL equal the captured sub throughout RUN.
REQ-024: alu_cclear SHALL be 1 for every RUN cycle and 0 otherwise.
REQ-025: alu_eop SHALL be 1 only in the RUN cycle where idx == len.
REQ-026: alu_s SHALL be written into result byte idx at the end of each RUN cycle.
REQ-027: Result bytes above len SHALL read 0; the final carry/borrow out is discarded (wraps modulo 2^(8*(len+1))).
REQ-028: Latency: start accepted at edge T; done high in cycle T+len+2; busy high in cycles T+1 .. T+len+2.
REQ-029: result SHALL hold its value in DONE and IDLE until the next accepted start.
REQ-030: start while busy SHALL be ignored with no effect on state or captured operands.
REQ-031: start in DONE SHALL be ignored; back-to-back operations need one IDLE cycle.
REQ-032: In IDLE and DONE all alu_* outputs SHALL be 0.

Reset
REQ-033: rst_n low SHALL force IDLE immediately, regardless of the clock.
REQ-034: Reset values: result 0, busy 0, done 0, idx 0, all alu_* outputs 0, captured registers 0.
REQ-035: Reset mid-RUN SHALL abort the operation; no done pulse SHALL follow.

Structure
REQ-036: Shared package SHALL hold the state enum (IDLE/RUN/DONE), BYTE_W, NBYTES, and the len width.
REQ-037: A single sub-module seq_byte_sel (byte-index mux of a/b, byte write-enable decode for result) SHALL be used; the FSM stays in add_sub_seq.
REQ-038: Registers only in add_sub_seq; the alu_* outputs SHALL be decoded from registered state and idx.

Verification
REQ-039: len=1, sub=0, a=0x00FF, b=0x0001 -> RUN 2 cycles, csel 0 then 1, eop on 2nd, result 0x00000100, done at T+3.
REQ-040: len=1, sub=1, a=0x0100, b=0x0001 -> result 0x000000FF; alu_sub_sel=1 both cycles.
REQ-041: len=3, sub=0, a=0xFFFFFFFF, b=0x00000001 -> result 0x00000000 (wrap), done at T+5.
REQ-042: len=0, a=0xAB, b=0x01, upper operand bytes 0xFF -> result 0x000000AC, single-cycle RUN with eop and cclear.
REQ-043: start pulsed during RUN with different operands -> ignored; result matches first operands only.
REQ-044: rst_n low in 2nd RUN cycle of len=3 -> IDLE, all outputs 0, no done; a subsequent start executes normally.

Source files
------------

// File: rtl/add_sub_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_sub_seq_pkg
//  Description : Shared constants and state encoding for the byte-serial
//                add/subtract sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_sub_seq_pkg;

  localparam int NBYTES = 4;  // maximum operand length in bytes
  localparam int BYTE_W = 8;  // byte width of the external add/sub datapath
  localparam int LEN_W  = 2;  // width of the len / byte-index fields

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : add_sub_seq_pkg
`default_nettype wire

// File: rtl/add_sub_seq_byte_sel.sv
`default_nettype none
// ============================================================================
//  Module      : seq_byte_sel
//  Description : Byte-index multiplexer for the two operands plus a one-hot
//                write-enable decode for the result byte lanes. Purely
//                combinational; everything is forced to zero when not enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_byte_sel
  import add_sub_seq_pkg::*;
#(
  parameter int NBYTES = add_sub_seq_pkg::NBYTES,
  parameter int BYTE_W = add_sub_seq_pkg::BYTE_W,
  parameter int IDX_W  = add_sub_seq_pkg::LEN_W
) (
  input  logic                     en,
  input  logic [IDX_W-1:0]         idx,
  input  logic [NBYTES*BYTE_W-1:0] a_word,
  input  logic [NBYTES*BYTE_W-1:0] b_word,
  output logic [BYTE_W-1:0]        byte_a,
  output logic [BYTE_W-1:0]        byte_b,
  output logic [NBYTES-1:0]        byte_we
);

  // Select operand byte idx; zero when the sequencer is not running.
  always_comb begin
    byte_a = '0;
    byte_b = '0;
    if (en) begin
      byte_a = a_word[idx*BYTE_W +: BYTE_W];
      byte_b = b_word[idx*BYTE_W +: BYTE_W];
    end
  end

  // One write enable per result byte lane.
  generate
    for (genvar i = 0; i < NBYTES; i++) begin : g_we
      assign byte_we[i] = en && (idx == IDX_W'(i));
    end
  endgenerate

endmodule : seq_byte_sel
`default_nettype wire

// File: rtl/add_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : add_sub_seq
//  Description : Byte-serial add/subtract sequencer. Walks the operands one
//                byte per cycle through an external add/sub datapath,
//                chaining its stored carry, and assembles the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_sub_seq
  import add_sub_seq_pkg::*;
#(
  parameter int NBYTES = add_sub_seq_pkg::NBYTES,
  parameter int BYTE_W = add_sub_seq_pkg::BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sub,
  input  logic [LEN_W-1:0]         len,
  input  logic [NBYTES*BYTE_W-1:0] a_word,
  input  logic [NBYTES*BYTE_W-1:0] b_word,
  output logic [BYTE_W-1:0]        alu_a,
  output logic [BYTE_W-1:0]        alu_b,
  output logic                     alu_csel,
  output logic                     alu_sub_sel,
  output logic                     alu_cclear,
  output logic                     alu_eop,
  input  logic [BYTE_W-1:0]        alu_s,
  output logic [NBYTES*BYTE_W-1:0] result,
  output logic                     busy,
  output logic                     done
);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [LEN_W-1:0]           r_idx;
  logic [LEN_W-1:0]           r_len;
  logic                       r_sub;
  logic [NBYTES*BYTE_W-1:0]   r_a;
  logic [NBYTES*BYTE_W-1:0]   r_b;
  logic [NBYTES*BYTE_W-1:0]   r_result;
  logic [NBYTES*BYTE_W-1:0]   w_result_next;
  logic [NBYTES-1:0]          w_byte_we;
  logic                       w_run;
  logic                       w_last;
  logic                       w_accept;

  assign w_run    = (r_state == ST_RUN);
  assign w_last   = (r_idx == r_len);
  assign w_accept = (r_state == ST_IDLE) && start;

  seq_byte_sel #(
    .NBYTES (NBYTES),
    .BYTE_W (BYTE_W),
    .IDX_W  (LEN_W)
  ) u_byte_sel (
    .en      (w_run),
    .idx     (r_idx),
    .a_word  (r_a),
    .b_word  (r_b),
    .byte_a  (alu_a),
    .byte_b  (alu_b),
    .byte_we (w_byte_we)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: DONE lasts exactly one cycle, so start there is ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Merge the returned sum byte into the lane selected by idx.
  always_comb begin
    w_result_next = r_result;
    for (int i = 0; i < NBYTES; i++) begin
      if (w_byte_we[i]) w_result_next[i*BYTE_W +: BYTE_W] = alu_s;
    end
  end

  // Operand capture on accepted start, then byte index walk and result build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_len    <= '0;
      r_sub    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_idx    <= '0;
      r_len    <= len;
      r_sub    <= sub;
      r_a      <= a_word;
      r_b      <= b_word;
      r_result <= '0;
    end else if (w_run) begin
      r_idx    <= r_idx + LEN_W'(1);
      r_result <= w_result_next;
    end
  end

  // Datapath controls are decoded from registered state only.
  assign alu_csel    = w_run && (r_idx != '0);
  assign alu_sub_sel = w_run && r_sub;
  assign alu_cclear  = w_run;
  assign alu_eop     = w_run && w_last;

  assign result = r_result;
  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);

endmodule : add_sub_seq
`default_nettype wire

// File: tb/tb_add_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_sub_seq
//  Description : Self-checking bench for add_sub_seq with a behavioural
//                model of the external byte add/sub datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_sub_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [1:0]  len;
  logic [31:0] a_word;
  logic [31:0] b_word;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_csel;
  logic        alu_sub_sel;
  logic        alu_cclear;
  logic        alu_eop;
  logic [7:0]  alu_s;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int n_vec;
  int n_bad;
  logic [31:0] exp_q[$];

  add_sub_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sub         (sub),
    .len         (len),
    .a_word      (a_word),
    .b_word      (b_word),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_csel    (alu_csel),
    .alu_sub_sel (alu_sub_sel),
    .alu_cclear  (alu_cclear),
    .alu_eop     (alu_eop),
    .alu_s       (alu_s),
    .result      (result),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External datapath: byte adder with a stored carry register.
  logic       dp_carry;
  logic       dp_cin;
  logic [8:0] dp_sum;
  always_comb begin
    dp_cin = alu_csel ? dp_carry : alu_sub_sel;
    dp_sum = {1'b0, alu_a} + {1'b0, (alu_sub_sel ? ~alu_b : alu_b)} + {8'd0, dp_cin};
    alu_s  = dp_sum[7:0];
  end
  always_ff @(posedge clk) begin
    if (alu_cclear) dp_carry <= dp_sum[8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic s, input logic [1:0] l,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    logic [63:0] mask;
    full = s ? ({32'd0, a} - {32'd0, b}) : ({32'd0, a} + {32'd0, b});
    mask = (64'd1 << (8 * (int'(l) + 1))) - 64'd1;
    return full[31:0] & mask[31:0];
  endfunction

  // Run one operation; inj > 0 pulses start with junk operands in that cycle.
  task automatic run_op(input logic s, input logic [1:0] l, input logic [31:0] a,
                        input logic [31:0] b, input int inj);
    int k;
    bit seen;
    logic [31:0] ex;
    logic [31:0] sh;
    exp_q.push_back(model(s, l, a, b));
    sub = s; len = l; a_word = a; b_word = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_word = ~a; b_word = ~b; sub = ~s; len = ~l;
    k = 1; seen = 0; ex = '0;
    while (k <= 8 && !seen) begin
      if (done) begin
        seen = 1;
        chk("latency", k, l + 2);
        chk("busy_in_done", {31'd0, busy}, 1);
        chk("alu_zero_done", {alu_a, alu_b, 4'd0, alu_csel, alu_sub_sel, alu_cclear, alu_eop}, 0);
        if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
        else begin
          ex = exp_q.pop_front();
          chk("result", result, ex);
        end
      end else begin
        sh = 32'(8 * (k - 1));
        chk("busy_run", {31'd0, busy}, 1);
        chk("cclear", {31'd0, alu_cclear}, 1);
        chk("csel", {31'd0, alu_csel}, {31'd0, k > 1});
        chk("eop", {31'd0, alu_eop}, {31'd0, k == int'(l) + 1});
        chk("sub_sel", {31'd0, alu_sub_sel}, {31'd0, s});
        chk("alu_a", {24'd0, alu_a}, (a >> sh) & 32'hFF);
        chk("alu_b", {24'd0, alu_b}, (b >> sh) & 32'hFF);
      end
      start = (k == inj);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_done", {31'd0, done}, 0);
    chk("result_hold", result, ex);
  endtask

  typedef struct {
    logic        s;
    logic [1:0]  l;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vt[8];
  int ndone;

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; len = 2'd0; a_word = '0; b_word = '0;
    #12;
    chk("rst_result", result, 0);
    chk("rst_ctl", {busy, done, alu_csel, alu_sub_sel, alu_cclear, alu_eop}, 0);
    chk("rst_alu", {alu_a, alu_b}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    vt[0] = '{1'b0, 2'd1, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100};
    vt[1] = '{1'b1, 2'd1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF};
    vt[2] = '{1'b0, 2'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vt[3] = '{1'b0, 2'd0, 32'hFFFF_FFAB, 32'hFFFF_FF01, 32'h0000_00AC};
    vt[4] = '{1'b1, 2'd3, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vt[5] = '{1'b1, 2'd2, 32'hAA12_3456, 32'h5565_4321, 32'h00AC_F135};
    vt[6] = '{1'b0, 2'd2, 32'h1180_8080, 32'h2280_8080, 32'h0001_0100};
    vt[7] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0000_0001, 32'h0000_00FF};

    for (int i = 0; i < 8; i++) begin
      chk("table_model", model(vt[i].s, vt[i].l, vt[i].a, vt[i].b), vt[i].r);
      run_op(vt[i].s, vt[i].l, vt[i].a, vt[i].b, 0);
    end

    // start pulsed in RUN with different operands, then start pulsed in DONE
    run_op(1'b0, 2'd3, 32'h1234_5678, 32'h1111_1111, 2);
    run_op(1'b1, 2'd1, 32'h0000_5000, 32'h0000_0FFF, 3);

    // Asynchronous reset in the second RUN cycle of a 4-byte operation
    sub = 1'b0; len = 2'd3; a_word = 32'h0102_0304; b_word = 32'h1010_1010; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {busy, done, alu_csel, alu_sub_sel, alu_cclear, alu_eop}, 0);
    chk("mid_rst_alu", {alu_a, alu_b}, 0);
    chk("mid_rst_result", result, 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("no_done_after_abort", ndone, 0);
    run_op(1'b0, 2'd3, 32'h0102_0304, 32'h1010_1010, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_add_sub_seq
`default_nettype wire
